// File: rtl/discrete_filter_scheduler.sv
// Shares one 17x17 multiplier across NUM_CHANNELS first-order low-pass filters, y += (x - y) * alpha.
// Latency: a strobe at cycle T commits all outputs together and pulses sample_done at T + 3*NUM_CHANNELS + 2.
// No backpressure: a strobe that arrives while a pass is running is dropped and sets the sticky overrun flag.
module discrete_filter_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int CLOCK_RATE   = 1000000,
    parameter int SAMPLE_RATE  = 48000
) (
    input  logic                      clk,
    input  logic                      I_RSTn,
    input  logic                      audio_clk_en,
    input  logic [16*NUM_CHANNELS-1:0] in_flat,
    input  logic [16*NUM_CHANNELS-1:0] alpha_flat,
    input  logic                      overrun_clr,
    output logic [16*NUM_CHANNELS-1:0] out_flat,
    output logic                      sample_done,
    output logic                      busy,
    output logic                      overrun
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

    generate
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
            $error("discrete_filter_scheduler: NUM_CHANNELS must be 1..16");
        end
        if (3 * NUM_CHANNELS + 2 > CLOCK_RATE / SAMPLE_RATE) begin : g_bad_rate
            $error("discrete_filter_scheduler: a sample pass does not fit in one sample period");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, MUL, WRITE, COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             ch_q, ch_d;
    logic signed [15:0]        x_q [NUM_CHANNELS];
    logic [15:0]               a_q [NUM_CHANNELS];
    logic signed [15:0]        y_q [NUM_CHANNELS];
    logic signed [16:0]        diff_q, diff_d;
    logic signed [33:0]        prod_q, prod_d;
    logic signed [15:0]        y_new;
    logic [16*NUM_CHANNELS-1:0] out_q;
    logic                      sample_done_q;
    logic                      overrun_q, overrun_d;
    logic                      unused_prod_bits;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    state_d = LOAD;
                    ch_d    = '0;
                end
            end
            LOAD:  state_d = MUL;
            MUL:   state_d = WRITE;
            WRITE: begin
                if (ch_q == LAST_CH) begin
                    state_d = COMMIT;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = LOAD;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set beats clear so a coincident overrun is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (audio_clk_en && state_q != IDLE) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // |x - y| < 2^16 and alpha < 1, so the floored step always fits back into 16 bits.
    always_comb begin
        diff_d = {x_q[ch_q][15], x_q[ch_q]} - {y_q[ch_q][15], y_q[ch_q]};
        prod_d = diff_q * $signed({1'b0, a_q[ch_q]});
        y_new  = y_q[ch_q] + prod_q[31:16];
    end
    assign unused_prod_bits = ^{prod_q[33:32], prod_q[15:0]};

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            diff_q        <= '0;
            prod_q        <= '0;
            out_q         <= '0;
            sample_done_q <= 1'b0;
            overrun_q     <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                x_q[k] <= '0;
                a_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            overrun_q     <= overrun_d;
            sample_done_q <= (state_q == COMMIT);
            if (state_q == IDLE && audio_clk_en) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    x_q[k] <= in_flat[16*k +: 16];
                    a_q[k] <= alpha_flat[16*k +: 16];
                end
            end
            if (state_q == LOAD) diff_q <= diff_d;
            if (state_q == MUL) prod_q <= prod_d;
            if (state_q == WRITE) y_q[ch_q] <= y_new;
            if (state_q == COMMIT) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    out_q[16*k +: 16] <= y_q[k];
                end
            end
        end
    end

    assign out_flat    = out_q;
    assign sample_done = sample_done_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
endmodule
